// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM encoding.
package serial_adder_pkg;

   // Default operand width; legal range is 2..32.
   localparam int unsigned DefaultWidth = 8;

   // 2'd3 is unused; the FSM recovers from it to StIdle.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/full_tasizan.sv
// 1-bit combinational full adder shared with the parallel adder designs.
module full_tasizan (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic cout,
   output logic s
);

   // Sum and carry of a single bit position.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full
// adder, with a carry flop linking consecutive bit positions.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_FLAG_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
`ifdef SERIAL_ADDER_OVF_FLAG_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_s, fa_cout;
   logic             last_bit;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
   logic             ovf_q, ovf_d;
`endif

   full_tasizan u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .cout (fa_cout),
      .s    (fa_s)
   );

   assign last_bit = (cnt_q == LastCnt);
   assign sum_next = {fa_s, sum_sr_q[WIDTH-1:1]};

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; start is honoured whenever the block is not busy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StShift;
         StShift: if (last_bit) state_d = StDone;
         StDone:  state_d = start ? StShift : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; busy and done are decoded from distinct states so never overlap.
   always_comb begin
      busy = (state_q == StShift);
      done = (state_q == StDone);
   end

   // Datapath next state: capture on accepted start, one bit per SHIFT cycle,
   // result registers written only on the final bit (i.e. on DONE entry).
   always_comb begin
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         StShift: begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            sum_sr_d = sum_next;
            carry_d  = fa_cout;
            // Counter parks at zero rather than stepping past WIDTH-1.
            cnt_d    = last_bit ? '0 : cnt_q + 1'b1;
            if (last_bit) begin
               s_d    = sum_next;
               cout_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
               // carry_q here is the carry into the MSB.
               ovf_d  = carry_q ^ fa_cout;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         s_q      <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a cycle-level reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout;
   logic [W-1:0] s;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
   logic         ovf;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .s     (s),
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
      int t;
      t = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (t > 2 ** (W - 1) - 1) || (t < -(2 ** (W - 1)));
   endfunction

   // Reference model: an accepted start yields the arithmetic sum W edges later.
   int           rem = 0;
   logic         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, pend_ovf = 1'b0;
   logic [W-1:0] m_s = '0;
   logic [W:0]   pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= 0;
         m_done <= 1'b0;
         m_s    <= '0;
         m_cout <= 1'b0;
         m_ovf  <= 1'b0;
      end else if (rem > 0) begin
         rem    <= rem - 1;
         m_done <= (rem == 1);
         if (rem == 1) begin
            m_s    <= pend[W-1:0];
            m_cout <= pend[W];
            m_ovf  <= pend_ovf;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            rem      <= W;
            pend     <= {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            pend_ovf <= signed_ovf(a, b, cin);
         end
      end
   end

   // Compare DUT against the model every cycle, clear of the clock edge.
   always @(posedge clk) begin
      #2;
      check("busy", 32'(busy), 32'(rem > 0));
      check("done", 32'(done), 32'(m_done));
      check("s", 32'(s), 32'(m_s));
      check("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      check("ovf", 32'(ovf), 32'(m_ovf));
`endif
   end

   task automatic fail_timeout(input string name);
      n_total++;
      $display("FAIL %s: done not seen within bound, expected a done pulse", name);
   endtask

   // One addition with hand-computed result; lat counts negedges from the start edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string nm, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      lat = 1;
      while (!done && lat < 4 * W) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         fail_timeout(nm);
      end else begin
         check({nm, "_s"}, 32'(s), 32'(es));
         check({nm, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_FLAG_EN
         check({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
         if (eo === 1'bx) $display("note: unexpected x in ovf literal");
`endif
      end
   endtask

   initial begin
      int lat, ndone, t;
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ndone, t;

      // Reset held with random inputs.
      a = W'($urandom); b = W'($urandom); cin = 1'b1; start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_s", 32'(s), 0);
      check("rst_cout", 32'(cout), 0);
      start = 1'b0;
      rst_n = 1'b1;

      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "basic", lat);
      check("basic_latency", 32'(lat), 32'(W + 1));
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01", lat);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff_ff_c", lat);
      run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "zero_c", lat);
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos", lat);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg", lat);

      // Start while busy must be ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      repeat (2 * W + 2) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check("busy_start_s", 32'(s), 32'h46);
            check("busy_start_cout", 32'(cout), 0);
         end
      end
      check("busy_start_dones", 32'(ndone), 1);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      t = 0;
      while (!done && t < 4 * W) begin
         @(negedge clk);
         t++;
      end
      if (!done) fail_timeout("b2b_first");
      else check("b2b_first_s", 32'(s), 32'h03);
      a = 8'h10; b = 8'h20; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 1;
      while (!done && t < 4 * W) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         fail_timeout("b2b_second");
      end else begin
         check("b2b_gap", 32'(t), 32'(W + 1));
         check("b2b_second_s", 32'(s), 32'h31);
         check("b2b_second_cout", 32'(cout), 0);
      end

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      check("async_rst_s", 32'(s), 0);
      check("async_rst_cout", 32'(cout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 0);
      check("abort_s", 32'(s), 0);
      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "after_abort", lat);
      run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, "alt_bits", lat);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
